fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage directly upstream of the control decoder. Owns the PC and issues
//  in-order word requests to instruction memory. Buffers returned words in a small FIFO and
//  presents {instr, instr_pc} to decode over a valid/ready handshake.
//  Consumes the decoder's PCSel plus the ALU branch/jump target to redirect fetch and flush
//  wrong-path instructions.
// PARAMETERS
//  XLEN        32            address/PC width
//  RESET_PC    32'h0000_0000 first fetch address after reset
//  FIFO_DEPTH  2             instruction buffer entries; also the total credit limit (power of 2, >=2)
// PORTS
//  clk          in   1     single clock, all state updates on rising edge
//  rst          in   1     synchronous, active-high reset
//  imem_req     out  1     fetch request valid
//  imem_addr    out  XLEN  fetch address (word aligned)
//  imem_gnt     in   1     memory accepts request this cycle (imem_req & imem_gnt = issue)
//  imem_rvalid  in   1     response word valid; responses return in issue order, >=1 cycle after grant
//  imem_rdata   in   32    response instruction word
//  pc_sel       in   1     redirect from decoder (PCSel); single-cycle pulse
//  pc_target    in   XLEN  redirect target (ALU result); bits[1:0] are forced to 0
//  instr        out  32    instruction to decoder
//  instr_pc     out  XLEN  PC of instr
//  instr_valid  out  1     instr/instr_pc valid
//  instr_ready  in   1     decoder consumes (instr_valid & instr_ready = pop)
// BEHAVIOUR
//  Reset: fetch_pc=RESET_PC, resp_pc=RESET_PC, outstanding=0, drop_cnt=0, FIFO empty,
//   state=BOOT. Outputs: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
//  FSM: BOOT -> RUN (unconditionally, one cycle after rst low; no requests in BOOT).
//   RUN -> FLUSH on pc_sel when the computed drop_cnt is >0.
//   FLUSH -> RUN when drop_cnt reaches 0 with no new pc_sel.
//   FLUSH + pc_sel stays in FLUSH; drop_cnt is recomputed.
//  Credit: imem_req = (state!=BOOT) & !pc_sel & (outstanding + fifo_count < FIFO_DEPTH).
//   imem_addr = fetch_pc. On issue: fetch_pc += 4 (wraps mod 2^XLEN) and outstanding += 1.
//  Response: on imem_rvalid, outstanding -= 1.
//   If drop_cnt>0: discard the word and drop_cnt -= 1.
//   Else: push {imem_rdata, resp_pc} and resp_pc += 4.
//   Credit guarantees the push never overflows.
//  Latency: issue at cycle t, rvalid at t+k. instr_valid is asserted no earlier than t+k+1.
//   There is no FIFO bypass.
//  Output: instr_valid = !fifo_empty & !pc_sel. instr/instr_pc = FIFO head, held stable until popped.
//  Redirect (pc_sel=1) in cycle t, registered at edge t+1:
//   - fetch_pc <= {pc_target[XLEN-1:2],2'b00}; resp_pc <= same.
//   - FIFO cleared; a push arriving in cycle t is discarded.
//   - drop_cnt <= outstanding - (imem_rvalid ? 1 : 0), counting only words not yet returned.
//   - The first request to the target issues in cycle t+1 at the earliest.
//  Simultaneous events:
//   - pc_sel with rvalid: the rvalid word is dropped.
//   - pc_sel with instr_ready: no pop occurs (instr_valid is 0).
//   - pop with push on a full FIFO cannot occur (credit rule).
//   - pop with push on a non-full FIFO: count unchanged.
//  Reset mid-operation: all state returns to reset values and in-flight responses are forgotten.
//   Instruction memory is reset by the same rst.
//  Arithmetic: outstanding and drop_cnt are clog2(FIFO_DEPTH)+1 bits and never underflow.
//   An rvalid with outstanding==0 is a protocol error; the bench asserts it never occurs.
// STRUCTURE
//  Shared package fetch_pkg holds:
//   - fetch_state_t {BOOT, RUN, FLUSH}
//   - XLEN default
//   - INSTR_W=32
//   - RISC-V NOP constant 32'h0000_0013 (reused by decode bubbles)
//  One sub-module: fetch_fifo, a synchronous FIFO (width INSTR_W+XLEN, depth FIFO_DEPTH) with
//   push, pop, flush, count, empty, full. flush has priority over push/pop.
//  PC/credit/drop logic and the FSM stay in fetch_unit.
// TESTING
//  1 Reset, then gnt=1 and 1-cycle rvalid returning addr-tagged words.
//    -> first imem_addr=0x0 in the cycle after BOOT; instr_pc sequence 0,4,8,C with ready=1.
//  2 instr_ready=0 for 10 cycles, gnt=1.
//    -> exactly FIFO_DEPTH issues, then imem_req=0; instr holds the word at 0x0 unchanged.
//  3 Two requests outstanding (latency 3); pulse pc_sel with pc_target=0x100.
//    -> both old words dropped; next instr_pc=0x100; state passes FLUSH then returns to RUN.
//  4 pc_sel in the same cycle as rvalid, one other request outstanding.
//    -> drop_cnt=1; only the word for pc_target is delivered.
//  5 pc_target=0x203 -> imem_addr=0x200. RESET_PC=32'hFFFF_FFFC -> next imem_addr wraps to 0x0.
//  6 Assert rst for one cycle mid-stream with the FIFO full.
//    -> next cycle instr_valid=0, imem_req=0; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
// Used by fetch_unit, fetch_fifo and decode.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  localparam int XLEN_DEF = 32;
  localparam int INSTR_W  = 32;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer for the fetch stage.
// flush wins over push and pop in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;

  assign rdata = mem_q[rd_q];
  assign count = cnt_q;
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(DEPTH));

  // Next pointers, occupancy and storage.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = wdata;
        wr_d = wr_q + AW'(1);
      end
      if (pop) begin
        rd_d = rd_q + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Storage is cleared on reset so the head reads as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, credit-limited imem requests,
// wrong-path drop on redirect, buffered hand-off to decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               XLEN       = XLEN_DEF,
  parameter logic [XLEN-1:0]  RESET_PC   = '0,
  parameter int               FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               pc_sel,
  input  logic [XLEN-1:0]    pc_target,
  output logic [INSTR_W-1:0] instr,
  output logic [XLEN-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = INSTR_W + XLEN;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic            fifo_full;
  logic [FW-1:0]   fifo_rdata;
  logic [CW:0]     credit_used;
  logic [XLEN-1:0] target_al;
  logic            issue;
  logic            push;
  logic            pop;

  assign target_al   = pc_target & ~XLEN'(3);
  assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign imem_req    = (state_q != BOOT) & ~pc_sel
                     & (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_addr   = fetch_pc_q;
  assign issue       = imem_req & imem_gnt;
  assign instr_valid = ~fifo_empty & ~pc_sel;
  assign pop         = instr_valid & instr_ready;
  assign instr       = fifo_rdata[FW-1:XLEN];
  assign instr_pc    = fifo_rdata[XLEN-1:0];

  // Fetch PC and in-flight request count.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + CW'(issue) - CW'(imem_rvalid);
    if (pc_sel) begin
      fetch_pc_d = target_al;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end
  end

  // Response routing: drop stale words, otherwise buffer them.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    resp_pc_d  = resp_pc_q;
    push       = 1'b0;
    if (imem_rvalid) begin
      if (drop_cnt_q != '0) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end else if (!pc_sel) begin
        push      = 1'b1;
        resp_pc_d = resp_pc_q + XLEN'(4);
      end
    end
    if (pc_sel) begin
      drop_cnt_d = outstanding_q - CW'(imem_rvalid);
      resp_pc_d  = target_al;
    end
  end

  // Fetch FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (pc_sel && drop_cnt_d != '0) state_d = FLUSH;
      end
      FLUSH: begin
        if (!pc_sel && drop_cnt_d == '0) state_d = RUN;
      end
      default: state_d = BOOT;
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (pc_sel),
    .wdata ({imem_rdata, resp_pc_q}),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  logic unused_ok;
  assign unused_ok = fifo_full;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with an in-order,
// fixed-latency instruction memory model.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic        pc_sel = 1'b0;
  logic [31:0] pc_target = '0;
  logic        ready = 1'b0;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instr, instr_pc;

  logic        req2, valid2;
  logic [31:0] addr2, instr2, pc2;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(gnt), .imem_rvalid(rvalid),
    .imem_rdata(rdata),
    .pc_sel(pc_sel), .pc_target(pc_target),
    .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(ready)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst),
    .imem_req(req2), .imem_addr(addr2),
    .imem_gnt(1'b1), .imem_rvalid(1'b0),
    .imem_rdata(32'h0),
    .pc_sel(1'b0), .pc_target(32'h0),
    .instr(instr2), .instr_pc(pc2),
    .instr_valid(valid2), .instr_ready(1'b0)
  );

  typedef struct {
    int          due;
    logic [31:0] addr;
  } pend_t;

  pend_t       pend[$];
  logic [63:0] exp_q[$];
  logic [31:0] popped[$];
  int          cyc = 0;
  int          lat = 1;
  int          n_tests = 0;
  int          n_fail = 0;
  int          n_issue = 0;
  int          n_iss2 = 0;
  bit          saw_flush = 0;
  logic [31:0] exp_fetch = '0;
  logic [31:0] exp2 = 32'hFFFF_FFFC;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] first_pop();
    if (popped.size() == 0) return 32'hDEAD_BEEF;
    return popped[0];
  endfunction

  // One clock cycle: drive memory response, observe, advance.
  task automatic cycle();
    logic [63:0] e;
    rvalid = 1'b0;
    rdata  = '0;
    if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
      rvalid = 1'b1;
      rdata  = word_of(pend[0].addr);
      void'(pend.pop_front());
    end
    #1;
    if (rst) begin
      pend.delete();
      exp_q.delete();
      exp_fetch = 32'h0;
      exp2      = 32'hFFFF_FFFC;
      n_iss2    = 0;
    end else begin
      if (rvalid) check("outst_nz", 64'(dut.outstanding_q != 0), 64'd1);
      if (dut.state_q == FLUSH) saw_flush = 1;
      if (pc_sel) begin
        check("req_sel", 64'(imem_req), 64'd0);
        check("vld_sel", 64'(instr_valid), 64'd0);
      end
      if (imem_req && gnt) begin
        check("addr", 64'(imem_addr), 64'(exp_fetch));
        exp_q.push_back({word_of(exp_fetch), exp_fetch});
        pend.push_back('{cyc + lat, imem_addr});
        exp_fetch += 32'd4;
        n_issue++;
      end
      if (req2) begin
        check("addr2", 64'(addr2), 64'(exp2));
        exp2 += 32'd4;
        n_iss2++;
      end
      if (instr_valid && ready) begin
        popped.push_back(instr_pc);
        if (exp_q.size() == 0) begin
          check("spurious", 64'(instr_pc), 64'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("pc", 64'(instr_pc), 64'(e[31:0]));
          check("instr", 64'(instr), 64'(e[63:32]));
        end
      end
      if (pc_sel) begin
        exp_q.delete();
        exp_fetch = pc_target & ~32'd3;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst    = 1'b1;
    pc_sel = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    popped.delete();
    n_issue   = 0;
    saw_flush = 0;
  endtask

  initial begin
    @(negedge clk);
    gnt = 1'b1;
    lat = 1;

    // 1: reset state, boot, sequential stream
    reset_dut();
    #1;
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'd0);
    check("rst_vld", 64'(instr_valid), 64'd0);
    check("rst_instr", 64'(instr), 64'd0);
    check("rst_ipc", 64'(instr_pc), 64'd0);
    check("rst_outst", 64'(dut.outstanding_q), 64'd0);
    cycle();
    #1;
    check("run_req", 64'(imem_req), 64'd1);
    check("run_addr", 64'(imem_addr), 64'd0);
    ready = 1'b1;
    repeat (12) cycle();
    check("seq0", 64'(first_pop()), 64'h0);
    check("seq_n", 64'(popped.size() >= 4), 64'd1);
    if (popped.size() >= 4) begin
      check("seq1", 64'(popped[1]), 64'h4);
      check("seq2", 64'(popped[2]), 64'h8);
      check("seq3", 64'(popped[3]), 64'hC);
    end

    // 2: decode stalled, credit limits issues
    ready = 1'b0;
    reset_dut();
    repeat (10) cycle();
    #1;
    check("stall_iss", 64'(n_issue), 64'd2);
    check("stall_req", 64'(imem_req), 64'd0);
    check("stall_vld", 64'(instr_valid), 64'd1);
    check("stall_pc", 64'(instr_pc), 64'h0);
    check("stall_ins", 64'(instr), 64'(word_of(32'h0)));
    ready = 1'b1;
    repeat (6) cycle();

    // 3: redirect with two words in flight
    reset_dut();
    lat = 3;
    repeat (3) cycle();
    #1;
    check("t3_outst", 64'(dut.outstanding_q), 64'd2);
    pc_sel    = 1'b1;
    pc_target = 32'h100;
    cycle();
    pc_sel = 1'b0;
    #1;
    check("t3_state", 64'(dut.state_q), 64'(FLUSH));
    check("t3_drop", 64'(dut.drop_cnt_q), 64'd2);
    popped.delete();
    repeat (14) cycle();
    check("t3_first", 64'(first_pop()), 64'h100);
    check("t3_run", 64'(dut.state_q), 64'(RUN));
    check("t3_flush", 64'(saw_flush), 64'd1);

    // 4: redirect coincident with a response
    reset_dut();
    lat = 2;
    repeat (3) cycle();
    pc_sel    = 1'b1;
    pc_target = 32'h40;
    cycle();
    pc_sel = 1'b0;
    #1;
    check("t4_drop", 64'(dut.drop_cnt_q), 64'd1);
    popped.delete();
    repeat (10) cycle();
    check("t4_first", 64'(first_pop()), 64'h40);

    // 5: target alignment and PC wrap on second instance
    lat = 1;
    repeat (3) cycle();
    pc_sel    = 1'b1;
    pc_target = 32'h203;
    cycle();
    pc_sel = 1'b0;
    #1;
    check("t5_addr", 64'(imem_addr), 64'h200);
    check("t5_wrap", 64'(addr2), 64'h4);
    check("t5_iss2", 64'(n_iss2), 64'd2);
    popped.delete();
    repeat (8) cycle();
    check("t5_first", 64'(first_pop()), 64'h200);

    // 6: reset with the buffer full
    ready = 1'b0;
    repeat (6) cycle();
    #1;
    check("t6_full", 64'(dut.fifo_count), 64'd2);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    check("t6_vld", 64'(instr_valid), 64'd0);
    check("t6_req", 64'(imem_req), 64'd0);
    cycle();
    #1;
    check("t6_req1", 64'(imem_req), 64'd1);
    check("t6_addr", 64'(imem_addr), 64'h0);
    ready = 1'b1;
    popped.delete();
    repeat (8) cycle();
    check("t6_first", 64'(first_pop()), 64'h0);

    // drain: everything issued must be delivered
    gnt = 1'b0;
    repeat (10) cycle();
    check("drain_exp", 64'(exp_q.size()), 64'd0);
    check("drain_mem", 64'(pend.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
